// File: rtl/smbus_ioexp_pkg.sv
// Shared widths and default parameters for the SMBus IO-expander input filter.
// Imported by the debounce bit and the filter top.
package smbus_ioexp_pkg;

    localparam int unsigned PIN_W     = 16;
    localparam int unsigned DEB_CNT_W = 4;

    typedef logic [PIN_W-1:0]     pin_t;
    typedef logic [DEB_CNT_W-1:0] cnt_t;

    localparam pin_t RESET_VAL_DEF = 16'hFFFF;
    localparam cnt_t DEB_TICKS_DEF = 4'd3;

endpackage

// File: rtl/ioexp_debounce_bit.sv
// One pin lane: 2-flop synchronizer, tick-based debounce counter and filtered level flop.
// Raises upd_o in the cycle before filt_o takes a new value.
module ioexp_debounce_bit
    import smbus_ioexp_pkg::*;
#(
    parameter cnt_t DEB_TICKS = DEB_TICKS_DEF,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic bypass_i,
    input  logic pin_i,
    output logic filt_o,
    output logic upd_o
);

    localparam cnt_t LastCnt = cnt_t'(DEB_TICKS - cnt_t'(1));

    logic s1_q, s2_q;
    logic filt_q, filt_d;
    cnt_t cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (bypass_i) begin
            filt_d = s2_q;
        end else if (s2_q != filt_q) begin
            cnt_d = cnt_q;
            if (tick_i) begin
                // Accept on the DEB_TICKS-th tick; counter never passes LastCnt.
                if (cnt_q == LastCnt) begin
                    filt_d = s2_q;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= RESET_VAL;
            s2_q   <= RESET_VAL;
            filt_q <= RESET_VAL;
            cnt_q  <= '0;
        end else begin
            s1_q   <= pin_i;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;
    assign upd_o  = filt_d != filt_q;

endmodule

// File: rtl/smbus_ioexp_input_filter.sv
// Debounced input stage for the SMBus IO expander: 16 filtered pins split into two ports,
// with a one-cycle change strobe and a sticky per-bit change mask.
module smbus_ioexp_input_filter
    import smbus_ioexp_pkg::*;
#(
    parameter cnt_t DEB_TICKS = DEB_TICKS_DEF,
    parameter pin_t RESET_VAL = RESET_VAL_DEF
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iClk_1ms,
    input  logic        iBypass,
    input  logic [15:0] iPin,
    input  logic [15:0] iClearMask,
    output logic [7:0]  oI0,
    output logic [7:0]  oI1,
    output logic        oChange,
    output logic [15:0] oChangeMask
);

    pin_t filt;
    pin_t upd;

    for (genvar i = 0; i < PIN_W; i++) begin : g_bit
        ioexp_debounce_bit #(
            .DEB_TICKS (DEB_TICKS),
            .RESET_VAL (RESET_VAL[i])
        ) u_bit (
            .clk_i    (iClk),
            .rst_i    (iRst),
            .tick_i   (iClk_1ms),
            .bypass_i (iBypass),
            .pin_i    (iPin[i]),
            .filt_o   (filt[i]),
            .upd_o    (upd[i])
        );
    end

    logic change_q, change_d;
    pin_t mask_q, mask_d;

    // Strobe and mask register on the same edge the filtered level updates; set beats clear.
    always_comb begin
        change_d = |upd;
        mask_d   = (mask_q & ~iClearMask) | upd;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            change_q <= 1'b0;
            mask_q   <= '0;
        end else begin
            change_q <= change_d;
            mask_q   <= mask_d;
        end
    end

    assign oI0         = filt[15:8];
    assign oI1         = filt[7:0];
    assign oChange     = change_q;
    assign oChangeMask = mask_q;

endmodule

// File: doc/smbus_ioexp_input_filter.md
SMBUS_IOEXP_INPUT_FILTER -- requirements
Module: smbus_ioexp_input_filter

Interface
REQ-001 SHALL have parameter DEB_TICKS, default 4'd3, number of consecutive iClk_1ms ticks a changed pin level must persist before acceptance (legal 1..15).
REQ-002 SHALL have parameter RESET_VAL, default 16'hFFFF, reset level of all pin stages ({P0,P1}, pull-up idle).
REQ-003 iClk  input  1  system clock; all logic on rising edge.
REQ-004 iRst  input  1  synchronous, active-high reset.
REQ-005 iClk_1ms  input  1  single-iClk-wide 1 ms tick enable.
REQ-006 iBypass  input  1  1 = debounce disabled, filtered level follows synchronized pin.
REQ-007 iPin  input  16  raw asynchronous pins, [15:8] = port 0, [7:0] = port 1.
REQ-008 iClearMask  input  16  per-bit clear of oChangeMask, one-cycle pulse.
REQ-009 oI0  output  8  filtered port 0 level, feeds expander iI0.
REQ-010 oI1  output  8  filtered port 1 level, feeds expander iI1.
REQ-011 oChange  output  1  one-iClk pulse when any filtered bit changes.
REQ-012 oChangeMask  output  16  sticky per-bit record of filtered changes.

Function
REQ-013 Each iPin bit SHALL pass a 2-flop synchronizer (s1, s2) before any other use.
REQ-014 Per bit, a 4-bit counter SHALL clear to 0 in any cycle where s2 equals the filtered level.
REQ-015 Per bit, when s2 differs from filtered and iClk_1ms=1, counter SHALL increment.
REQ-016 When s2 differs, iClk_1ms=1 and counter == DEB_TICKS-1, filtered SHALL load s2 and counter SHALL clear, same cycle.
REQ-017 A pin returning to the filtered level before acceptance SHALL clear the counter and produce no output change (glitch rejected).
REQ-018 Acceptance latency SHALL be: 2 iClk synchronizer + DEB_TICKS ticks of sustained difference + 1 iClk register; counting starts with the first tick after s2 differs.
REQ-019 With iBypass=1, filtered SHALL load s2 every cycle and all counters SHALL be held at 0 (pin-to-output latency 3 iClk).
REQ-020 Toggling iBypass from 1 to 0 SHALL not alter filtered; counting resumes from 0.
REQ-021 oChange SHALL be 1 for exactly the cycle after any filtered bit updates to a new value, independent of how many bits change together.
REQ-022 oChangeMask[n] SHALL set the cycle filtered[n] changes; clear only by iClearMask[n]=1.
REQ-023 Simultaneous set and clear on the same bit SHALL leave the bit set (set wins).
REQ-024 Counters SHALL saturate-free: counter never exceeds DEB_TICKS-1 by construction; no wrap-around.
REQ-025 oI0 = filtered[15:8], oI1 = filtered[7:0], both registered, no combinational path from iPin.

Reset
REQ-026 While iRst=1: s1, s2, filtered SHALL load RESET_VAL; counters 0; oChange 0; oChangeMask 16'h0000.
REQ-027 iClk_1ms ticks during reset SHALL be ignored; reset asserted mid-debounce SHALL abort counting with no output change beyond the reset value.
REQ-028 First cycle after reset release, outputs SHALL equal RESET_VAL, oChange 0, even if pins differ.

Structure
REQ-029 Package smbus_ioexp_pkg SHALL hold PIN_W (16), DEB_CNT_W (4), default RESET_VAL and default DEB_TICKS.
REQ-030 One sub-module, ioexp_debounce_bit (synchronizer, counter, filtered flop), SHALL be instantiated 16 times; change detect and mask logic stay in top.

Verification
REQ-031 Reset, iPin=16'hFFFF, DEB_TICKS=3, drive iPin[15]=0 held -> oI0[7] falls after 3rd tick following s2 change; oChange one pulse; oChangeMask=16'h8000.
REQ-032 iPin[0]=0 for 2 ticks then back to 1 -> oI1[0] stays 1, oChange never pulses, mask unchanged.
REQ-033 iBypass=1, iPin 16'hFFFF->16'h00FF -> oI0=8'h00 exactly 3 iClk later, single oChange pulse, mask=16'hFF00.
REQ-034 Mask=16'h8000, iClearMask=16'h8000 in same cycle bit 15 changes again -> mask stays 16'h8000; next clear alone -> 16'h0000.
REQ-035 iRst asserted after 2 of 3 ticks of a pending change -> outputs RESET_VAL, mask 0, counters 0; after release, change needs a full 3 new ticks.
REQ-036 All 16 pins toggle together, held -> all bits update same cycle, oChange one pulse, mask=16'hFFFF.
